eth_header_capture: RTL and testbench
=====================================

Name: eth_header_capture

Overview:
Upstream stage of eth_header_parser. It accepts a byte-wide frame stream with a valid/ready/last handshake and captures the first HDR_BYTES bytes of each frame into an 18-entry byte array. It presents that array with a held header_valid until the consumer acknowledges it, then discards the rest of the frame. Runt frames shorter than MIN_HDR bytes are dropped and counted.

Parameters:
HDR_BYTES, 18, bytes captured per frame; 14 Ethernet header + 4 optional VLAN tag; must be ≤18.
MIN_HDR, 14, minimum frame length that yields a header; shorter frames are runts.
CNT_W, 16, width of the runt counter.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
s_data  input  8 (byte_t)  stream byte.
s_valid  input  1  s_data valid.
s_last  input  1  marks the final byte of a frame.
s_ready  output  1  stage can accept a byte.
header_bytes  output  byte_t [0:17]  captured bytes; byte 0 is the first byte on the wire.
header_valid  output  1  header_bytes is stable and complete; held until header_ready.
header_ready  input  1  consumer acknowledge.
hdr_len  output  5  number of bytes actually captured, 14..18; valid while header_valid is high.
runt_err  output  1  one-cycle pulse when a runt frame is dropped.
runt_count  output  CNT_W  saturating count of runt frames.

Behaviour:
- Reset (async assert, sync release): state=CAPTURE, byte index=0, all header_bytes=0, header_valid=0, hdr_len=0, runt_err=0, runt_count=0, s_ready=1.
- A byte is accepted on a cycle with s_valid && s_ready.
- States: CAPTURE (collecting header bytes) and DRAIN (discarding payload until s_last).
- CAPTURE, idx=0 accept: write header_bytes[0]=s_data and zero entries 1..17 on the same edge; idx←1.
- CAPTURE, accept at idx k>0: header_bytes[k]←s_data; idx←k+1.
- CAPTURE, accept with k+1==HDR_BYTES and !s_last: header_valid←1, hdr_len←HDR_BYTES, state←DRAIN, idx←0.
- CAPTURE, accept with s_last and k+1≥MIN_HDR: header_valid←1, hdr_len←k+1, unfilled bytes remain 0, state stays CAPTURE, idx←0.
- CAPTURE, accept with s_last and k+1<MIN_HDR: runt. No header_valid; runt_err pulses in the next cycle; runt_count increments, saturating at all-ones; idx←0.
- DRAIN: accept and discard every byte; s_last → state←CAPTURE.
- Latency: header_valid rises on the cycle after the completing byte is accepted.
- Handshake: header_valid stays high and header_bytes/hdr_len stay frozen until a cycle with header_ready=1; header_valid clears on that edge. header_ready while header_valid=0 is ignored.
- Backpressure: s_ready = !(state==CAPTURE && idx==0 && header_valid && !header_ready).
  - Draining continues while a header is pending.
  - The next frame's first byte stalls until the pending header is acknowledged.
  - A same-cycle acknowledge and first-byte accept is legal and must lose neither event.
- Frame of exactly HDR_BYTES bytes (s_last on byte 17): takes the s_last path; no DRAIN.
- s_data/s_last are don't-care when s_valid=0.
- Reset mid-frame: the partial frame is lost and any pending header is dropped; the stream is assumed to restart at a frame boundary.
- No combinational path from s_data to any output. s_ready depends combinationally only on header_ready and registered state.

Decomposition:
- eth_parser_pkg holds the shared types and constants:
  - byte_t, mac_addr_t, ethertype_t (already present).
  - ETH_HDR_LEN=14, ETH_VLAN_HDR_LEN=18.
  - A capture_state_t enum {CAPTURE, DRAIN}.
- No sub-module; the saturating counter stays inline.
- Top-level integration instantiates eth_header_capture feeding eth_header_parser:
  - header_valid→header_valid.
  - header_bytes→header_bytes.
  - header_ready tied high or driven by downstream.

Test Plan:
1. 64-byte frame, bytes 0x00..0x3F, header_ready=1 → header_valid 1 cycle after byte 17; header_bytes[0..17]=0x00..0x11; hdr_len=18; bytes 18..63 accepted with s_ready=1; parser sees dest_mac=0x000102030405, ethertype=0x0C0D.
2. 15-byte frame, s_last on byte 14 → header_valid=1; hdr_len=15; header_bytes[15..17]=0; no DRAIN.
3. 10-byte frame → no header_valid; runt_err single pulse; runt_count=1. Then a 20-byte frame → normal header, runt_count stays 1.
4. header_ready=0 held, two back-to-back 30-byte frames → first payload fully drained; s_ready=0 at the second frame's first byte. Raise header_ready → second frame's byte 0 accepted on the same cycle header_valid clears; second header correct.
5. Random s_valid gaps (~50% duty) on a 40-byte frame → captured bytes identical to the gap-free case.
6. Assert rst at byte 9 of a frame → all outputs 0 immediately (async). After release, a fresh 18-byte frame yields a correct header with hdr_len=18.

Source files
------------

// File: rtl/eth_parser_pkg.sv
// ---------------------------------------------------------------------------
// eth_parser_pkg
// Shared types and constants for the Ethernet header capture/parse pipeline.
//   byte_t           : one stream byte
//   mac_addr_t       : 48-bit MAC address
//   ethertype_t      : 16-bit EtherType field
//   ETH_HDR_LEN      : plain Ethernet II header length (bytes)
//   ETH_VLAN_HDR_LEN : header length including one 802.1Q tag (bytes)
//   capture_state_t  : capture stage state (collecting header / draining payload)
// ---------------------------------------------------------------------------
package eth_parser_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [47:0] mac_addr_t;
    typedef logic [15:0] ethertype_t;

    localparam int ETH_HDR_LEN      = 14;
    localparam int ETH_VLAN_HDR_LEN = 18;

    typedef enum logic [0:0] {
        CAPTURE = 1'b0,
        DRAIN   = 1'b1
    } capture_state_t;

endpackage

// File: rtl/eth_header_capture.sv
// ---------------------------------------------------------------------------
// eth_header_capture
// Captures the first HDR_BYTES bytes of every frame arriving on a byte-wide
// valid/ready/last stream and presents them as a held header until the
// consumer acknowledges. The remainder of a long frame is discarded. Frames
// shorter than MIN_HDR bytes are dropped and counted as runts.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   s_data       : stream byte
//   s_valid      : s_data valid
//   s_last       : final byte of the frame
//   s_ready      : stage accepts a byte this cycle
//   header_bytes : captured bytes, element 0 is first on the wire
//   header_valid : header_bytes/hdr_len complete and frozen until header_ready
//   header_ready : consumer acknowledge
//   hdr_len      : number of bytes captured (MIN_HDR..HDR_BYTES)
//   runt_err     : one-cycle pulse when a runt frame is dropped
//   runt_count   : saturating runt frame counter
// ---------------------------------------------------------------------------
module eth_header_capture
    import eth_parser_pkg::*;
#(
    parameter int HDR_BYTES = ETH_VLAN_HDR_LEN,
    parameter int MIN_HDR   = ETH_HDR_LEN,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  byte_t             s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output byte_t [0:17]      header_bytes,
    output logic              header_valid,
    input  logic              header_ready,
    output logic [4:0]        hdr_len,
    output logic              runt_err,
    output logic [CNT_W-1:0]  runt_count
);

    localparam logic [4:0]       HDR_BYTES_L = 5'(HDR_BYTES);
    localparam logic [4:0]       MIN_HDR_L   = 5'(MIN_HDR);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    capture_state_t      state_r;
    logic [4:0]          idx_r;
    byte_t [0:17]        header_bytes_r;
    logic                header_valid_r;
    logic [4:0]          hdr_len_r;
    logic                runt_err_r;
    logic [CNT_W-1:0]    runt_count_r;

    logic                ready_s;
    logic                accept_s;
    logic [4:0]          next_idx_s;

    // Only the first byte of a new frame is held back, and only while the
    // previous header is still waiting for its acknowledge. An acknowledge in
    // the same cycle releases the stall so both events happen on one edge.
    assign ready_s    = !((state_r == CAPTURE) && (idx_r == 5'd0) &&
                          header_valid_r && !header_ready);
    assign accept_s   = s_valid && ready_s;
    assign next_idx_s = idx_r + 5'd1;

    // Capture/drain state machine, header register file and runt counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= CAPTURE;
            idx_r          <= 5'd0;
            header_bytes_r <= '0;
            header_valid_r <= 1'b0;
            hdr_len_r      <= 5'd0;
            runt_err_r     <= 1'b0;
            runt_count_r   <= '0;
        end else begin
            runt_err_r <= 1'b0;

            // Acknowledge first; a header completed below on the same edge
            // overrides it (cannot happen in practice, byte 0 needs the ack).
            if (header_valid_r && header_ready) begin
                header_valid_r <= 1'b0;
            end

            if (accept_s) begin
                case (state_r)
                    CAPTURE: begin
                        // First byte clears the whole array so short headers
                        // leave their unused tail at zero.
                        if (idx_r == 5'd0) begin
                            header_bytes_r    <= '0;
                            header_bytes_r[0] <= s_data;
                        end else begin
                            header_bytes_r[idx_r] <= s_data;
                        end

                        if (s_last) begin
                            idx_r <= 5'd0;
                            if (next_idx_s >= MIN_HDR_L) begin
                                header_valid_r <= 1'b1;
                                hdr_len_r      <= next_idx_s;
                            end else begin
                                runt_err_r <= 1'b1;
                                if (runt_count_r != CNT_MAX) begin
                                    runt_count_r <= runt_count_r + CNT_W'(1);
                                end
                            end
                        end else if (next_idx_s == HDR_BYTES_L) begin
                            header_valid_r <= 1'b1;
                            hdr_len_r      <= HDR_BYTES_L;
                            state_r        <= DRAIN;
                            idx_r          <= 5'd0;
                        end else begin
                            idx_r <= next_idx_s;
                        end
                    end
                    DRAIN: begin
                        if (s_last) begin
                            state_r <= CAPTURE;
                        end
                    end
                    default: begin
                        state_r <= CAPTURE;
                        idx_r   <= 5'd0;
                    end
                endcase
            end
        end
    end

    assign s_ready      = ready_s;
    assign header_bytes = header_bytes_r;
    assign header_valid = header_valid_r;
    assign hdr_len      = hdr_len_r;
    assign runt_err     = runt_err_r;
    assign runt_count   = runt_count_r;

endmodule

// File: tb/tb_eth_header_capture.sv
// ---------------------------------------------------------------------------
// tb_eth_header_capture
// Directed bench for eth_header_capture. Expected headers, header-valid rise
// cycles and runt counter values are queued as frames are driven and checked
// by a monitor when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_eth_header_capture;
    import eth_parser_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    byte_t         s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    byte_t [0:17]  header_bytes;
    logic          header_valid;
    logic          header_ready;
    logic [4:0]    hdr_len;
    logic          runt_err;
    logic [15:0]   runt_count;

    typedef struct {
        byte_t [0:17] b;
        logic [4:0]   len;
    } exp_t;

    exp_t exp_q[$];
    int   rise_q[$];
    int   runt_q[$];
    int   exp_runt = 0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    eth_header_capture dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .header_bytes (header_bytes),
        .header_valid (header_valid),
        .header_ready (header_ready),
        .hdr_len      (hdr_len),
        .runt_err     (runt_err),
        .runt_count   (runt_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: what a frame of len bytes starting at value base
    // should produce (header or runt).
    task automatic push_exp(input int len, input int base);
        exp_t e;
        int   n;
        e.b = '0;
        n = (len >= 18) ? 18 : len;
        for (int i = 0; i < n; i++) e.b[i] = byte_t'(base + i);
        e.len = 5'(n);
        if (len >= 14) begin
            exp_q.push_back(e);
        end else begin
            if (exp_runt < 65535) exp_runt++;
            runt_q.push_back(exp_runt);
        end
    endtask

    task automatic send_byte(input byte_t d, input logic last, output int acc, output bit ok);
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        ok      = 1'b0;
        acc     = 0;
        for (int w = 0; w < 500 && !ok; w++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                acc = cyc;
                ok  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = byte_t'($urandom);
        s_last  = 1'($urandom);
        check("byte_accepted", 144'(ok), 144'(1));
    endtask

    task automatic send_frame(input int len, input int base, input int first, input int upto, input bit gaps);
        int acc;
        bit ok;
        int done_idx;
        done_idx = (len >= 18) ? 17 : len - 1;
        for (int i = first; i < upto; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_byte(byte_t'(base + i), (i == len - 1), acc, ok);
            if (len >= 14 && i == done_idx) rise_q.push_back(acc + 1);
        end
    endtask

    // Monitor: hold/clear behaviour, rise latency, header contents, runts.
    byte_t [0:17] pb;
    logic [4:0]   pl;
    logic         pv = 1'b0;
    logic         pr = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            pv <= 1'b0;
            pr <= 1'b0;
        end else begin
            if (pv && !pr) begin
                check("hold_valid", 144'(header_valid), 144'(1));
                check("hold_bytes", header_bytes, pb);
                check("hold_len", 144'(hdr_len), 144'(pl));
            end
            if (pv && pr) check("clear_on_ack", 144'(header_valid), 144'(0));
            if (header_valid && !pv) begin
                if (rise_q.size() == 0) check("rise_expected", 144'(rise_q.size()), 144'(1));
                else check("rise_cycle", 144'(cyc), 144'(rise_q.pop_front()));
            end
            if (header_valid && header_ready) begin
                if (exp_q.size() == 0) begin
                    check("header_expected", 144'(exp_q.size()), 144'(1));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("header_bytes", header_bytes, e.b);
                    check("hdr_len", 144'(hdr_len), 144'(e.len));
                end
            end
            if (runt_err) begin
                if (runt_q.size() == 0) check("runt_expected", 144'(runt_q.size()), 144'(1));
                else check("runt_count_at_err", 144'(runt_count), 144'(runt_q.pop_front()));
            end
            pv <= header_valid;
            pr <= header_ready;
            pb <= header_bytes;
            pl <= hdr_len;
        end
    end

    initial begin
        int acc;
        bit ok;
        rst          = 1'b1;
        s_data       = 8'h00;
        s_valid      = 1'b0;
        s_last       = 1'b0;
        header_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bytes", header_bytes, 144'(0));
        check("rst_valid", 144'(header_valid), 144'(0));
        check("rst_len", 144'(hdr_len), 144'(0));
        check("rst_runt_err", 144'(runt_err), 144'(0));
        check("rst_runt_count", 144'(runt_count), 144'(0));
        check("rst_ready", 144'(s_ready), 144'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: long frame, header then drain
        push_exp(64, 8'h00);
        send_frame(64, 8'h00, 0, 64, 1'b0);

        // 2: 15-byte frame on the s_last path
        push_exp(15, 8'h50);
        send_frame(15, 8'h50, 0, 15, 1'b0);

        // 3: runt then a normal 20-byte frame
        push_exp(10, 8'h60);
        send_frame(10, 8'h60, 0, 10, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("runt_count_1", 144'(runt_count), 144'(1));
        push_exp(20, 8'h70);
        send_frame(20, 8'h70, 0, 20, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("runt_count_kept", 144'(runt_count), 144'(1));

        // 4: header pending with two back-to-back frames
        header_ready = 1'b0;
        push_exp(30, 8'hA0);
        send_frame(30, 8'hA0, 0, 30, 1'b0);
        push_exp(30, 8'hC0);
        s_data  = 8'hC0;
        s_valid = 1'b1;
        s_last  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_ready", 144'(s_ready), 144'(0));
            check("stall_valid", 144'(header_valid), 144'(1));
        end
        @(posedge clk);
        #1;
        header_ready = 1'b1;
        send_byte(8'hC0, 1'b0, acc, ok);
        @(negedge clk);
        check("ack_with_accept", 144'(header_valid), 144'(0));
        @(posedge clk);
        #1;
        send_frame(30, 8'hC0, 1, 30, 1'b0);

        // 5: same 40-byte frame without and with s_valid gaps
        push_exp(40, 8'h20);
        send_frame(40, 8'h20, 0, 40, 1'b0);
        push_exp(40, 8'h20);
        send_frame(40, 8'h20, 0, 40, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // 6: asynchronous reset in the middle of a frame
        send_frame(40, 8'h40, 0, 9, 1'b0);
        rst = 1'b1;
        #1;
        check("arst_bytes", header_bytes, 144'(0));
        check("arst_valid", 144'(header_valid), 144'(0));
        check("arst_len", 144'(hdr_len), 144'(0));
        check("arst_runt_count", 144'(runt_count), 144'(0));
        check("arst_ready", 144'(s_ready), 144'(1));
        @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_runt = 0;
        @(posedge clk);
        #1;
        push_exp(18, 8'h80);
        send_frame(18, 8'h80, 0, 18, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("exp_q_empty", 144'(exp_q.size()), 144'(0));
        check("rise_q_empty", 144'(rise_q.size()), 144'(0));
        check("runt_q_empty", 144'(runt_q.size()), 144'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
